// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: bus-side scheduler between the CPU bus and the UART core register port.
// Buffers TX/RX bytes in FIFOs and sequences one core access per state by polling core status.
// Optional build macro: UART_FIFO_RX_THRESH_IRQ_EN adds a programmable RX irq threshold at 0x4.
module uart_fifo_ctrl #(
  parameter int TX_AW      = 4,
  parameter int RX_AW      = 4,
  parameter int TX_HOLDOFF = 16
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic [3:0]  bus_address,
  input  logic [31:0] bus_data_i,
  output logic [31:0] bus_data_o,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        uart_irq,
  output logic [3:0]  u_address,
  output logic [31:0] u_data_o,
  input  logic [31:0] u_data_i,
  output logic        u_read,
  output logic        u_write
);
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int HW       = $clog2(TX_HOLDOFF + 1);

  typedef enum logic [1:0] {ST_INIT, ST_POLL, ST_RECV, ST_SEND} state_t;
  state_t state, state_next;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TX_AW:0] tx_wr, tx_rd, tx_count;
  logic [RX_AW:0] rx_wr, rx_rd, rx_count;
  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic           tx_push, tx_pop, rx_push, rx_pop;
  logic           cpu_wr_data, cpu_rd_data, cpu_wr_ctrl;
  logic [HW-1:0]  holdoff;
  logic           rx_ie, txe_ie, rx_ovf, tx_ovf;
  logic           rx_irq_term;
  logic [7:0]     tx_head, rx_head;
  logic           unused_bits;

  assign unused_bits = ^{bus_data_i[31:8], u_data_i[31:8]};

  // FIFO occupancy and CPU/controller access decode
  assign tx_count    = tx_wr - tx_rd;
  assign rx_count    = rx_wr - rx_rd;
  assign tx_full     = tx_count[TX_AW];
  assign rx_full     = rx_count[RX_AW];
  assign tx_empty    = (tx_wr == tx_rd);
  assign rx_empty    = (rx_wr == rx_rd);
  assign tx_head     = tx_mem[tx_rd[TX_AW-1:0]];
  assign rx_head     = rx_mem[rx_rd[RX_AW-1:0]];
  assign cpu_wr_data = bus_write && (bus_address == 4'h8);
  assign cpu_rd_data = bus_read  && (bus_address == 4'h8);
  assign cpu_wr_ctrl = bus_write && (bus_address == 4'hC);
  assign tx_push     = cpu_wr_data && !tx_full;
  assign tx_pop      = (state == ST_SEND) && !tx_empty;
  assign rx_push     = (state == ST_RECV) && !rx_full;
  assign rx_pop      = cpu_rd_data && !rx_empty;

  // FIFO storage (no reset needed; contents are qualified by pointers)
  always_ff @(posedge clk_bus) begin
    if (tx_push) tx_mem[tx_wr[TX_AW-1:0]] <= bus_data_i[7:0];
    if (rx_push) rx_mem[rx_wr[RX_AW-1:0]] <= u_data_i[7:0];
  end

  // FIFO pointers; push and pop are independent and may coincide
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + (TX_AW+1)'(1);
      if (tx_pop)  tx_rd <= tx_rd + (TX_AW+1)'(1);
      if (rx_push) rx_wr <= rx_wr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rd <= rx_rd + (RX_AW+1)'(1);
    end
  end

  // State register
  always_ff @(posedge clk_bus) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  // Next-state and core-port strobes; strobes are held low while reset is asserted
  always_comb begin
    state_next = state;
    u_read     = 1'b0;
    u_write    = 1'b0;
    u_address  = 4'hC;
    u_data_o   = '0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          u_write    = 1'b1;
          state_next = ST_POLL;
        end
        ST_POLL: begin
          u_read = 1'b1;
          if (u_data_i[1] && !rx_full)
            state_next = ST_RECV;
          else if (u_data_i[0] && !tx_empty && (holdoff == '0))
            state_next = ST_SEND;
        end
        ST_RECV: begin
          u_read     = 1'b1;
          u_address  = 4'h8;
          state_next = ST_POLL;
        end
        ST_SEND: begin
          u_write    = 1'b1;
          u_address  = 4'h8;
          u_data_o   = {24'b0, tx_head};
          state_next = ST_POLL;
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  // Post-SEND settle counter, saturating at zero
  always_ff @(posedge clk_bus) begin
    if (rst)                    holdoff <= '0;
    else if (state == ST_SEND)  holdoff <= HW'(TX_HOLDOFF);
    else if (holdoff != '0)     holdoff <= holdoff - HW'(1);
  end

`ifdef UART_FIFO_RX_THRESH_IRQ_EN
  logic [RX_AW:0] rx_thresh, rx_thresh_eff;
  assign rx_thresh_eff = (rx_thresh == '0) ? (RX_AW+1)'(1) : rx_thresh;
  assign rx_irq_term   = (rx_count >= rx_thresh_eff) && rx_ie;

  // RX interrupt threshold register
  always_ff @(posedge clk_bus) begin
    if (rst)                                     rx_thresh <= (RX_AW+1)'(1);
    else if (bus_write && bus_address == 4'h4)   rx_thresh <= bus_data_i[RX_AW:0];
  end
`else
  assign rx_irq_term = !rx_empty && rx_ie;
`endif

  // Control/status flags and registered interrupt
  always_ff @(posedge clk_bus) begin
    if (rst) begin
      rx_ie    <= 1'b0;
      txe_ie   <= 1'b0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
      uart_irq <= 1'b0;
    end else begin
      if (cpu_wr_data && tx_full) tx_ovf <= 1'b1;
      if (cpu_wr_ctrl) begin
        rx_ie  <= bus_data_i[4];
        txe_ie <= bus_data_i[3];
        if (bus_data_i[6]) rx_ovf <= 1'b0;
        if (bus_data_i[5]) tx_ovf <= 1'b0;
      end
      uart_irq <= rx_irq_term || (tx_empty && txe_ie);
    end
  end

  // CPU read mux
  always_comb begin
    bus_data_o = '0;
    if (bus_read) begin
      case (bus_address)
        4'h0: begin
          bus_data_o[TX_AW:0]     = tx_count;
          bus_data_o[8 +: RX_AW+1] = rx_count;
        end
`ifdef UART_FIFO_RX_THRESH_IRQ_EN
        4'h4: bus_data_o[RX_AW:0] = rx_thresh;
`endif
        4'h8: if (!rx_empty) bus_data_o = {24'b0, rx_head};
        4'hC: bus_data_o = {25'b0, rx_ovf, tx_ovf, rx_ie, txe_ie, 1'b0, !rx_empty, !tx_full};
        default: bus_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl with a behavioural UART core model and byte scoreboards.
module tb_uart_fifo_ctrl;
  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bus_address;
  logic [31:0] bus_data_i, bus_data_o;
  logic        bus_read, bus_write, uart_irq;
  logic [3:0]  u_address;
  logic [31:0] u_data_o, u_data_i;
  logic        u_read, u_write;

  uart_fifo_ctrl #(.TX_AW(4), .RX_AW(4), .TX_HOLDOFF(HOLD)) dut (
    .clk_bus(clk), .rst(rst), .bus_address(bus_address), .bus_data_i(bus_data_i),
    .bus_data_o(bus_data_o), .bus_read(bus_read), .bus_write(bus_write), .uart_irq(uart_irq),
    .u_address(u_address), .u_data_o(u_data_o), .u_data_i(u_data_i),
    .u_read(u_read), .u_write(u_write)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: status {rx_avail, tx_idle}; RX bytes offered by the stimulus, consumed on data reads
  logic       tx_idle = 1'b0;
  logic [7:0] rx_src [64];
  int         rx_offered = 0;
  int         rx_taken = 0;

  always_comb begin
    u_data_i = '0;
    if (u_address == 4'hC)      u_data_i = {30'b0, (rx_offered != rx_taken), tx_idle};
    else if (u_address == 4'h8) u_data_i = {24'b0, rx_src[rx_taken % 64]};
  end

  always @(posedge clk) if (!rst && u_read && u_address == 4'h8) rx_taken <= rx_taken + 1;

  // Record every core SEND with its cycle stamp
  logic [31:0] sends_d [64];
  int unsigned sends_c [64];
  int send_n = 0;
  int send_chk = 0;
  always @(negedge clk) begin
    if (!rst && u_write && u_address == 4'h8) begin
      sends_d[send_n % 64] <= u_data_o;
      sends_c[send_n % 64] <= cyc;
      send_n <= send_n + 1;
    end
  end

  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] val;
    string       name;
  } vec_t;
  vec_t tbl [10];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus_address = a; bus_data_i = d; bus_write = 1'b1;
    tick();
    bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    bus_address = a; bus_read = 1'b1;
    #1 d = bus_data_o;
    tick();
    bus_read = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic push_tx(input logic [7:0] b);
    if (tx_exp.size() < 16) tx_exp.push_back(b);
    bus_wr(4'h8, {24'b0, b});
  endtask

  task automatic offer_rx(input logic [7:0] b);
    rx_src[rx_offered % 64] = b;
    rx_exp.push_back(b);
    rx_offered++;
  endtask

  task automatic pop_rx_check(input string name);
    logic [31:0] d;
    logic [7:0]  e;
    bus_rd(4'h8, d);
    if (rx_exp.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got %h with no byte expected", name, d);
    end else begin
      e = rx_exp.pop_front();
      check(name, d, {24'b0, e});
    end
  endtask

  task automatic wait_sends(input int target, input int budget);
    int n = 0;
    while (send_n < target && n < budget) begin tick(); n++; end
    checks++;
    if (send_n < target) begin
      errors++;
      $display("FAIL send_timeout: got %0d sends expected %0d", send_n, target);
    end
  endtask

  task automatic wait_taken(input int target, input int budget);
    int n = 0;
    while (rx_taken < target && n < budget) begin tick(); n++; end
    checks++;
    if (rx_taken < target) begin
      errors++;
      $display("FAIL recv_timeout: got %0d recvs expected %0d", rx_taken, target);
    end
  endtask

  task automatic check_sends();
    logic [7:0] e;
    int unsigned gap;
    while (send_chk < send_n) begin
      if (tx_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL send_extra: got %h with no byte expected", sends_d[send_chk % 64]);
      end else begin
        e = tx_exp.pop_front();
        check("send_data", sends_d[send_chk % 64], {24'b0, e});
      end
      if (send_chk > 0) begin
        gap = sends_c[send_chk % 64] - sends_c[(send_chk - 1) % 64];
        checks++;
        if (gap < HOLD + 1) begin
          errors++;
          $display("FAIL send_gap: got %0d cycles required >= %0d", gap, HOLD + 1);
        end
      end
      send_chk++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int sn;

    tbl[0] = '{1'b0, 4'h0, 32'h0000_0010, "tx_count_full"};
    tbl[1] = '{1'b0, 4'hC, 32'h0000_0020, "status_tx_ovf"};
    tbl[2] = '{1'b1, 4'hC, 32'h0000_0020, "clr_tx_ovf"};
    tbl[3] = '{1'b0, 4'hC, 32'h0000_0000, "status_ovf_clr"};
    tbl[4] = '{1'b1, 4'h4, 32'h0000_0007, "wr_thresh"};
`ifdef UART_FIFO_RX_THRESH_IRQ_EN
    tbl[5] = '{1'b0, 4'h4, 32'h0000_0007, "rd_thresh"};
`else
    tbl[5] = '{1'b0, 4'h4, 32'h0000_0000, "rd_thresh"};
`endif
    tbl[6] = '{1'b1, 4'h4, 32'h0000_0001, "wr_thresh1"};
    tbl[7] = '{1'b1, 4'hC, 32'h0000_0008, "set_txe_ie"};
    tbl[8] = '{1'b0, 4'hC, 32'h0000_0008, "status_txe_ie"};
    tbl[9] = '{1'b1, 4'hC, 32'h0000_0000, "clr_ie"};

    rst = 1'b1; bus_address = '0; bus_data_i = '0; bus_read = 1'b0; bus_write = 1'b0;

    // Reset state and INIT/POLL sequence
    repeat (3) tick();
    check("rst_u_write", u_write, 0);
    check("rst_u_read", u_read, 0);
    check("rst_irq", uart_irq, 0);
    rst = 1'b0;
    #1;
    check("init_write", {u_write, u_read, u_address}, {1'b1, 1'b0, 4'hC});
    check("init_data", u_data_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("poll_read", {u_write, u_read, u_address}, {1'b0, 1'b1, 4'hC});
    end
    check("idle_irq", uart_irq, 0);
    rd_check("status_reset", 4'hC, 32'h1);
    rd_check("counts_reset", 4'h0, 32'h0);
    rd_check("rx_empty_read", 4'h8, 32'h0);

    // Three bytes sent in order with holdoff spacing
    tx_idle = 1'b1;
    push_tx(8'h41); push_tx(8'h42); push_tx(8'h43);
    wait_sends(3, 200);
    check_sends();

    // Overflow of TX FIFO with idle-less core, then register table
    tx_idle = 1'b0;
    tick();
    sn = send_n;
    for (int i = 0; i < 17; i++) push_tx(8'h80 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr) bus_wr(tbl[i].addr, tbl[i].val);
      else              rd_check(tbl[i].name, tbl[i].addr, tbl[i].val);
    end
    check("no_send_busy", send_n, sn);
    tx_idle = 1'b1;
    wait_sends(sn + 16, 16 * 20 + 100);
    check_sends();
    rd_check("counts_drained", 4'h0, 32'h0);
    bus_wr(4'hC, 32'h08);
    tick(); tick();
    check("txe_irq_on", uart_irq, 1);
    bus_wr(4'hC, 32'h00);
    tick(); tick();
    check("txe_irq_off", uart_irq, 0);

    // RX byte with rx_ie
    bus_wr(4'hC, 32'h10);
    tick(); tick();
    check("rx_irq_idle", uart_irq, 0);
    offer_rx(8'h5A);
    for (int i = 0; i < 10 && !uart_irq; i++) tick();
    check("rx_irq_on", uart_irq, 1);
    check("rx_recv_count", rx_taken, 1);
    rd_check("status_rx", 4'hC, 32'h13);
    pop_rx_check("rx_data_5a");
    tick(); tick();
    check("rx_irq_off", uart_irq, 0);
    bus_wr(4'hC, 32'h00);

    // RX FIFO full: TX still served, core byte held back until CPU pops
    for (int i = 0; i < 16; i++) offer_rx(8'h10 + 8'(i * 3));
    wait_taken(17, 300);
    rd_check("rx_count_full", 4'h0, 32'h1000);
    offer_rx(8'hEE);
    sn = send_n;
    push_tx(8'h99);
    wait_sends(sn + 1, 100);
    check_sends();
    repeat (40) tick();
    check("no_recv_full", rx_taken, 17);
    rd_check("status_rx_full", 4'hC, 32'h03);
    pop_rx_check("rx_pop_first");
    wait_taken(18, 30);
    rd_check("rx_count_refill", 4'h0, 32'h1000);
    for (int i = 0; i < 16; i++) pop_rx_check("rx_drain");
    rd_check("rx_empty_after", 4'h8, 32'h0);

`ifdef UART_FIFO_RX_THRESH_IRQ_EN
    // Threshold interrupt
    bus_wr(4'h4, 32'h4);
    bus_wr(4'hC, 32'h10);
    for (int i = 0; i < 3; i++) offer_rx(8'hA0 + 8'(i));
    wait_taken(21, 60);
    tick(); tick(); tick();
    check("thresh_irq_3", uart_irq, 0);
    offer_rx(8'hA3);
    wait_taken(22, 30);
    tick(); tick(); tick();
    check("thresh_irq_4", uart_irq, 1);
    for (int i = 0; i < 4; i++) pop_rx_check("thresh_drain");
`endif

    // Reset discards buffered TX bytes
    tx_idle = 1'b0;
    push_tx(8'h77);
    rst = 1'b1;
    tick(); tick();
    check("rst_mid_strobe", {u_write, u_read}, 2'b00);
    rst = 1'b0;
    tx_exp.delete();
    tick();
    rd_check("rst_counts", 4'h0, 32'h0);
    rd_check("rst_status", 4'hC, 32'h1);
    sn = send_n;
    tx_idle = 1'b1;
    repeat (40) tick();
    check("rst_no_send", send_n, sn);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
